avmm_word_responder: RTL and testbench
======================================

# avmm_word_responder

Avalon-MM slave (responder) that serves the 16-bit read/write traffic issued by the layer-engine masters: a byte-addressed word memory with configurable wait-state injection, fixed pipelined read latency, `readdatavalid` signalling and byte-enable writes. Sits on the same bus segment as the SDRAM controller and stands in for the weight/layer-output region during on-chip runs and master verification.

## Interface
- `BASE_ADDR`, 32'd800: byte address of word 0.
- `DEPTH_WORDS`, 1024: number of 16-bit words (power of two).
- `READ_LAT`, 2: cycles from read accept to `readdatavalid` (1..4).
- `WAIT_CYCLES`, 0: `waitrequest` cycles inserted before every accept (0..15).
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `chipselect`  in  1  slave selected.
- `byteenable`  in  2  write lane enables; ignored for reads.
- `read_n`  in  1  active-low read request.
- `write_n`  in  1  active-low write request.
- `address`  in  32  byte address; bit 0 ignored.
- `writedata`  in  16  write data.
- `waitrequest`  out  1  high = request not accepted this cycle.
- `readdatavalid`  out  1  one-cycle strobe per accepted read.
- `readdata`  out  16  read data, valid only with `readdatavalid`.
- `err`  out  1  sticky protocol/range error.
- `toHexLed`  out  32  {read count[15:0], write count[15:0]}.

## Operation
- Request = `chipselect & (!read_n | !write_n)`. Accept = request & `!waitrequest` at rising edge.
- Word index = (`address` − `BASE_ADDR`) >> 1. In range iff `address` ≥ `BASE_ADDR` and index < `DEPTH_WORDS`.
- Write accept, in range: lane 0 (`writedata[7:0]`) written if `byteenable[0]`, lane 1 if `byteenable[1]`; write count +1.
- Write accept, out of range: dropped, `err` set, count +1.
- Read accept: entry pushed into READ_LAT-deep valid/data pipe; in range returns stored word, out of range returns 16'hDEAD and sets `err`; read count +1.
- `read_n` and `write_n` both low: accepted as protocol violation, nothing performed, no `readdatavalid`, `err` set, neither count changes.
- Counters wrap at 16'hFFFF → 0. `err` clears only on reset.
- FSM: IDLE — request and WAIT_CYCLES=0: `waitrequest` low (combinational), accept, stay IDLE; request and WAIT_CYCLES>0: load counter with WAIT_CYCLES, go STALL, `waitrequest` high. STALL — `waitrequest` high while counter>0, decrement each cycle; at 0 `waitrequest` low, accept, go IDLE. Request dropped or changed (read/write/address) during STALL: set `err`, go IDLE, nothing performed.
- Idle (no request): `waitrequest` low in IDLE.
- Memory contents not reset; undefined until written.

## Timing
- Reset values: state IDLE, `waitrequest` 0, `readdatavalid` 0, `readdata` 16'h0000, `err` 0, both counts 0; read pipe flushed, in-flight reads discarded with no strobe.
- Read accepted at edge N → `readdatavalid`=1 and `readdata` valid during cycle N+READ_LAT, exactly one cycle. `readdata` holds last value otherwise.
- Back-to-back reads (WAIT_CYCLES=0): one accept per cycle, responses in order, continuous strobes.
- Per-access wait: WAIT_CYCLES+1 cycles from request assert to accept.
- Write at edge N visible to a read accepted at edge N+1.
- Writes may follow reads with responses still in flight; pipe unaffected.

## Structure
- Package `avmm_resp_pkg`: FSM state enum (IDLE, STALL), 16'hDEAD out-of-range constant, counter width, address-decode helper function.
- Sub-module `sp_ram_16`: single-port DEPTH_WORDS×16 RAM, 2-bit byte-enable write, registered read (1 cycle); remaining READ_LAT−1 stages in top-level pipe.

## Test plan
- Reset, write 16'hF00D to 800 (be=11), read 800 → `readdatavalid` at accept+2, `readdata`=16'hF00D, `toHexLed`=32'h0001_0001.
- Write 16'h1234 to 802, then be=01 write 16'hAB56 → read 802 returns 16'h1256.
- Four consecutive reads 800..806 with WAIT_CYCLES=0 → four consecutive strobes, data in address order.
- WAIT_CYCLES=3, read 800 → `waitrequest` high 3 cycles, accept on 4th, strobe 2 cycles later; drop `read_n` mid-stall → `err`=1, no strobe.
- Read 798 and 800+2·1024 → 16'hDEAD both, `err`=1; write there → memory unchanged.
- Assert `reset_n` low one cycle after a read accept → no `readdatavalid`, all outputs at reset values, `err` 0.

Source files
------------

// File: rtl/avmm_resp_pkg.sv
// Shared types, constants and the address-window decode used by the
// Avalon-MM word responder.
package avmm_resp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [15:0] OOR_DATA = 16'hDEAD;
  localparam int          CNT_W    = 16;
  localparam int          WAIT_W   = 4;

  // True when the byte address falls inside the word window; bit 0 is ignored.
  function automatic logic addr_in_range(input logic [31:0] addr,
                                         input logic [31:0] base,
                                         input logic [31:0] depth);
    logic [31:0] word;
    word = (addr - base) >> 1'b1;
    return (addr >= base) && (word < depth);
  endfunction

endpackage

// File: rtl/sp_ram_16.sv
// Single-port 16-bit word RAM with per-byte write enables and a registered
// read port. Contents are not reset; only the read register is.
module sp_ram_16 #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [1:0]    be_i,
  input  logic [AW-1:0] addr_i,
  input  logic [15:0]   wdata_i,
  output logic [15:0]   rdata_o
);

  logic [15:0] mem_q [DEPTH];
  logic [15:0] rdata_q;

  // Byte-lane writes into the storage array
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      if (be_i[0]) begin
        mem_q[addr_i][7:0] <= wdata_i[7:0];
      end
      if (be_i[1]) begin
        mem_q[addr_i][15:8] <= wdata_i[15:8];
      end
    end
  end

  // Registered read; holds its value between reads
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rdata_q <= 16'h0000;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/avmm_word_responder.sv
// Avalon-MM responder: byte-addressed 16-bit word memory with wait-state
// injection, fixed read latency, byte-enable writes and a sticky error flag.
module avmm_word_responder
  import avmm_resp_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'd800,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_LAT    = 2,
  parameter int          WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic [1:0]  byteenable,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [31:0] address,
  input  logic [15:0] writedata,
  output logic        waitrequest,
  output logic        readdatavalid,
  output logic [15:0] readdata,
  output logic        err,
  output logic [31:0] toHexLed
);

  localparam int AW = $clog2(DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  cnt_q, cnt_d;
  logic               snap_rd_n_q, snap_wr_n_q;
  logic [31:0]        snap_addr_q;

  logic               req_s, changed_s, accept_s, abort_s, wait_s;
  logic               is_rd_s, is_wr_s, is_both_s, hit_s;
  logic               ram_we_s, ram_re_s;
  logic [AW-1:0]      ram_addr_s;
  logic [15:0]        ram_rdata_s, head_s, rdata_s;

  logic               oor_q, err_q;
  logic [READ_LAT-1:0] vld_q;
  logic [CNT_W-1:0]   rd_cnt_q, wr_cnt_q;

  assign req_s     = chipselect & (~read_n | ~write_n);
  assign is_rd_s   = ~read_n & write_n;
  assign is_wr_s   = read_n & ~write_n;
  assign is_both_s = ~read_n & ~write_n;
  assign hit_s     = addr_in_range(address, BASE_ADDR, 32'(DEPTH_WORDS));
  assign ram_addr_s = AW'((address - BASE_ADDR) >> 1'b1);
  assign changed_s = ~req_s | (read_n != snap_rd_n_q) | (write_n != snap_wr_n_q)
                   | (address != snap_addr_q);

  // Wait-state FSM: decides waitrequest, accept and stall aborts
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wait_s   = 1'b0;
    accept_s = 1'b0;
    abort_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_s) begin
          if (WAIT_CYCLES == 0) begin
            accept_s = 1'b1;
          end else begin
            // The IDLE cycle already counts as the first wait state.
            wait_s  = 1'b1;
            cnt_d   = WAIT_W'(WAIT_CYCLES - 1);
            state_d = ST_STALL;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STALL: begin
        if (changed_s) begin
          wait_s  = 1'b1;
          abort_s = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          wait_s = 1'b1;
          cnt_d  = cnt_q - 4'd1;
        end else begin
          accept_s = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM state, stall counter and the request snapshot compared during a stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      snap_rd_n_q <= 1'b1;
      snap_wr_n_q <= 1'b1;
      snap_addr_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == ST_IDLE) begin
        snap_rd_n_q <= read_n;
        snap_wr_n_q <= write_n;
        snap_addr_q <= address;
      end
    end
  end

  assign ram_we_s = accept_s & is_wr_s & hit_s;
  assign ram_re_s = accept_s & is_rd_s & hit_s;

  sp_ram_16 #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .rst_n_i (reset_n),
    .we_i    (ram_we_s),
    .re_i    (ram_re_s),
    .be_i    (byteenable),
    .addr_i  (ram_addr_s),
    .wdata_i (writedata),
    .rdata_o (ram_rdata_s)
  );

  // Read-valid pipe, out-of-range tag, sticky error and access counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q    <= '0;
      oor_q    <= 1'b0;
      err_q    <= 1'b0;
      rd_cnt_q <= 16'd0;
      wr_cnt_q <= 16'd0;
    end else begin
      vld_q[0] <= accept_s & is_rd_s;
      for (int i = 1; i < READ_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
      end
      if (accept_s && is_rd_s) begin
        oor_q    <= ~hit_s;
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
      if (accept_s && is_wr_s) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if (abort_s || (accept_s && (is_both_s || !hit_s))) begin
        err_q <= 1'b1;
      end
    end
  end

  assign head_s = oor_q ? OOR_DATA : ram_rdata_s;

  generate
    if (READ_LAT == 1) begin : g_lat1
      assign rdata_s = head_s;
    end else begin : g_latn
      logic [15:0] dat_q [READ_LAT-1];

      // Remaining latency stages; each loads only when its entry is valid
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < READ_LAT - 1; i++) begin
            dat_q[i] <= 16'h0000;
          end
        end else begin
          if (vld_q[0]) begin
            dat_q[0] <= head_s;
          end
          for (int i = 1; i < READ_LAT - 1; i++) begin
            if (vld_q[i]) begin
              dat_q[i] <= dat_q[i-1];
            end
          end
        end
      end

      assign rdata_s = dat_q[READ_LAT-2];
    end
  endgenerate

  assign waitrequest   = wait_s;
  assign readdatavalid = vld_q[READ_LAT-1];
  assign readdata      = rdata_s;
  assign err           = err_q;
  assign toHexLed      = {rd_cnt_q, wr_cnt_q};

endmodule

// File: tb/tb_avmm_word_responder.sv
// Bench for avmm_word_responder: a zero-wait instance and a three-wait instance
// driven by a vector table, directed corner sequences and a random model run.
module tb_avmm_word_responder;

  localparam int          LAT  = 2;
  localparam logic [15:0] DEAD = 16'hDEAD;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cs   [2];
  logic        rd_n [2];
  logic        wr_n [2];
  logic [1:0]  be   [2];
  logic [31:0] addr [2];
  logic [15:0] wdat [2];
  logic        wreq [2];
  logic        rdv  [2];
  logic [15:0] rdat [2];
  logic        errf [2];
  logic [31:0] led  [2];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  avmm_word_responder #(.BASE_ADDR(32'd800), .DEPTH_WORDS(1024), .READ_LAT(2), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs[0]), .byteenable(be[0]), .read_n(rd_n[0]),
    .write_n(wr_n[0]), .address(addr[0]), .writedata(wdat[0]), .waitrequest(wreq[0]),
    .readdatavalid(rdv[0]), .readdata(rdat[0]), .err(errf[0]), .toHexLed(led[0]));

  avmm_word_responder #(.BASE_ADDR(32'd800), .DEPTH_WORDS(1024), .READ_LAT(2), .WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .chipselect(cs[1]), .byteenable(be[1]), .read_n(rd_n[1]),
    .write_n(wr_n[1]), .address(addr[1]), .writedata(wdat[1]), .waitrequest(wreq[1]),
    .readdatavalid(rdv[1]), .readdata(rdat[1]), .err(errf[1]), .toHexLed(led[1]));

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [15:0] d;
    logic [1:0]  b;
    logic [15:0] exp_rd;
    bit          exp_err;
    logic [31:0] exp_led;
  } vec_t;

  typedef struct {
    int          due;
    logic [15:0] data;
  } resp_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic idle(input int u);
    cs[u] = 1'b0; rd_n[u] = 1'b1; wr_n[u] = 1'b1;
  endtask

  // One complete access: counts wait cycles, then for reads the cycles to readdatavalid.
  task automatic txn(input int u, input bit wr, input logic [31:0] a, input logic [15:0] d,
                     input logic [1:0] b, output int waits, output int lat, output logic [15:0] rd);
    @(negedge clk);
    cs[u] = 1'b1; rd_n[u] = wr; wr_n[u] = ~wr; addr[u] = a; wdat[u] = d; be[u] = b;
    waits = 0; lat = 0; rd = 16'h0000;
    #1;
    while (wreq[u] === 1'b1 && waits < 32) begin
      @(negedge clk); #1; waits++;
    end
    @(negedge clk);
    idle(u);
    lat = 1;
    if (!wr) begin
      while (rdv[u] !== 1'b1 && lat < 16) begin
        @(negedge clk); lat++;
      end
      rd = rdat[u];
    end
  endtask

  vec_t        tbl [15];
  logic [15:0] burst_exp [4];
  logic [31:0] oor_tab [5];
  logic [15:0] mdl_mem [1024];
  resp_t       pend [$];
  resp_t       rsp;
  int          w, lat, strobes, idx, r;
  logic [15:0] rd, last_d, m_rc, m_wc, d_in;
  logic [31:0] a_in;
  logic [1:0]  b_in;
  logic        m_err, exp_v, cs_v, rdn_v, wrn_v, hit;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 32'd800,  16'hF00D, 2'b11, 16'h0000, 1'b0, 32'h0000_0001};
    tbl[1]  = '{1'b0, 32'd800,  16'h0000, 2'b11, 16'hF00D, 1'b0, 32'h0001_0001};
    tbl[2]  = '{1'b1, 32'd802,  16'h1234, 2'b11, 16'h0000, 1'b0, 32'h0001_0002};
    tbl[3]  = '{1'b1, 32'd802,  16'hAB56, 2'b01, 16'h0000, 1'b0, 32'h0001_0003};
    tbl[4]  = '{1'b0, 32'd802,  16'h0000, 2'b11, 16'h1256, 1'b0, 32'h0002_0003};
    tbl[5]  = '{1'b1, 32'd803,  16'h7777, 2'b10, 16'h0000, 1'b0, 32'h0002_0004};
    tbl[6]  = '{1'b0, 32'd803,  16'h0000, 2'b11, 16'h7756, 1'b0, 32'h0003_0004};
    tbl[7]  = '{1'b1, 32'd2846, 16'h5A5A, 2'b11, 16'h0000, 1'b0, 32'h0003_0005};
    tbl[8]  = '{1'b0, 32'd2846, 16'h0000, 2'b11, 16'h5A5A, 1'b0, 32'h0004_0005};
    tbl[9]  = '{1'b0, 32'd798,  16'h0000, 2'b11, DEAD,     1'b1, 32'h0005_0005};
    tbl[10] = '{1'b0, 32'd2848, 16'h0000, 2'b11, DEAD,     1'b1, 32'h0006_0005};
    tbl[11] = '{1'b1, 32'd798,  16'h1111, 2'b11, 16'h0000, 1'b1, 32'h0006_0006};
    tbl[12] = '{1'b1, 32'd2848, 16'h2222, 2'b11, 16'h0000, 1'b1, 32'h0006_0007};
    tbl[13] = '{1'b0, 32'd2846, 16'h0000, 2'b11, 16'h5A5A, 1'b1, 32'h0007_0007};
    tbl[14] = '{1'b0, 32'd800,  16'h0000, 2'b11, 16'hF00D, 1'b1, 32'h0008_0007};
    burst_exp = '{16'hF00D, 16'h7756, 16'h4444, 16'h6666};
    oor_tab   = '{32'd798, 32'd799, 32'd2848, 32'd0, 32'hFFFF_FFFE};

    for (int u = 0; u < 2; u++) begin
      idle(u); addr[u] = 32'd0; wdat[u] = 16'h0000; be[u] = 2'b00;
    end
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check($sformatf("rst%0d waitrequest", u), wreq[u], 1'b0);
      check($sformatf("rst%0d readdatavalid", u), rdv[u], 1'b0);
      check($sformatf("rst%0d readdata", u), rdat[u], 16'h0000);
      check($sformatf("rst%0d err", u), errf[u], 1'b0);
      check($sformatf("rst%0d toHexLed", u), led[u], 32'h0);
    end
    reset_n = 1'b1;

    // Vector table on the zero-wait instance
    for (int i = 0; i < 15; i++) begin
      txn(0, tbl[i].wr, tbl[i].a, tbl[i].d, tbl[i].b, w, lat, rd);
      check($sformatf("tbl%0d waits", i), w, 0);
      if (!tbl[i].wr) begin
        check($sformatf("tbl%0d latency", i), lat, LAT);
        check($sformatf("tbl%0d readdata", i), rd, tbl[i].exp_rd);
      end
      check($sformatf("tbl%0d err", i), errf[0], tbl[i].exp_err);
      check($sformatf("tbl%0d toHexLed", i), led[0], tbl[i].exp_led);
    end

    // Back-to-back reads: continuous in-order strobes
    txn(0, 1'b1, 32'd804, 16'h4444, 2'b11, w, lat, rd);
    txn(0, 1'b1, 32'd806, 16'h6666, 2'b11, w, lat, rd);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      exp_v = (k >= 2 && k <= 5);
      check($sformatf("burst%0d valid", k), rdv[0], exp_v);
      if (exp_v) check($sformatf("burst%0d data", k), rdat[0], burst_exp[k-2]);
      if (k < 4) begin
        cs[0] = 1'b1; rd_n[0] = 1'b0; wr_n[0] = 1'b1; addr[0] = 32'd800 + 32'(2 * k);
        #1 check($sformatf("burst%0d waitrequest", k), wreq[0], 1'b0);
      end else begin
        idle(0);
      end
    end

    // Three wait states: write, read, aborted read, read again
    txn(1, 1'b1, 32'd800, 16'hF00D, 2'b11, w, lat, rd);
    check("w3 write waits", w, 3);
    txn(1, 1'b0, 32'd800, 16'h0000, 2'b11, w, lat, rd);
    check("w3 read waits", w, 3);
    check("w3 read latency", lat, LAT);
    check("w3 read data", rd, 16'hF00D);
    check("w3 err before abort", errf[1], 1'b0);
    @(negedge clk);
    cs[1] = 1'b1; rd_n[1] = 1'b0; wr_n[1] = 1'b1; addr[1] = 32'd800;
    #1 check("w3 abort waitrequest", wreq[1], 1'b1);
    @(negedge clk);
    @(negedge clk);
    idle(1);
    strobes = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (rdv[1] === 1'b1) strobes++;
    end
    check("w3 abort strobes", strobes, 0);
    check("w3 abort err", errf[1], 1'b1);
    check("w3 abort counts", led[1], 32'h0001_0001);
    txn(1, 1'b0, 32'd800, 16'h0000, 2'b11, w, lat, rd);
    check("w3 post-abort waits", w, 3);
    check("w3 post-abort data", rd, 16'hF00D);
    check("w3 post-abort counts", led[1], 32'h0002_0001);

    // Reset one cycle after a read accept discards the in-flight response
    @(negedge clk);
    cs[0] = 1'b1; rd_n[0] = 1'b0; wr_n[0] = 1'b1; addr[0] = 32'd802;
    @(negedge clk);
    idle(0);
    reset_n = 1'b0;
    #1;
    check("midrst readdatavalid", rdv[0], 1'b0);
    check("midrst readdata", rdat[0], 16'h0000);
    check("midrst err", errf[0], 1'b0);
    check("midrst toHexLed", led[0], 32'h0);
    check("midrst waitrequest", wreq[0], 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    strobes = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rdv[0] === 1'b1) strobes++;
    end
    check("midrst strobes", strobes, 0);

    // Random traffic against a transaction-level model
    for (int i = 0; i < 16; i++) begin
      d_in = 16'($urandom);
      txn(0, 1'b1, 32'd800 + 32'(2 * i), d_in, 2'b11, w, lat, rd);
      mdl_mem[i] = d_in;
    end
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    m_err = 1'b0; m_rc = 16'd0; m_wc = 16'd0; last_d = 16'h0000;
    for (int n = 0; n < 500; n++) begin
      @(negedge clk);
      exp_v = 1'b0;
      if (pend.size() > 0 && pend[0].due == n) begin
        rsp = pend.pop_front();
        last_d = rsp.data;
        exp_v = 1'b1;
      end
      check($sformatf("rnd%0d readdatavalid", n), rdv[0], exp_v);
      check($sformatf("rnd%0d readdata", n), rdat[0], last_d);
      check($sformatf("rnd%0d err", n), errf[0], m_err);
      check($sformatf("rnd%0d toHexLed", n), led[0], {m_rc, m_wc});

      r = $urandom_range(0, 15);
      a_in = 32'd800 + 32'($urandom_range(0, 31));
      d_in = 16'($urandom);
      b_in = 2'($urandom_range(0, 3));
      cs_v = (r >= 2);
      rdn_v = ~((r >= 2 && r <= 7) || r == 13 || r == 14);
      wrn_v = ~((r >= 8 && r <= 12) || r == 13 || r == 15);
      if (r < 2) begin
        rdn_v = 1'($urandom_range(0, 1));
        wrn_v = 1'($urandom_range(0, 1));
      end
      if (r >= 14) a_in = oor_tab[$urandom_range(0, 4)];
      cs[0] = cs_v; rd_n[0] = rdn_v; wr_n[0] = wrn_v; addr[0] = a_in; wdat[0] = d_in; be[0] = b_in;

      if (cs_v && (!rdn_v || !wrn_v)) begin
        if (!rdn_v && !wrn_v) begin
          m_err = 1'b1;
        end else begin
          hit = (a_in >= 32'd800) && (((a_in - 32'd800) >> 1) < 32'd1024);
          idx = int'((a_in - 32'd800) >> 1);
          if (!hit) m_err = 1'b1;
          if (!rdn_v) begin
            m_rc = m_rc + 16'd1;
            pend.push_back('{n + LAT, hit ? mdl_mem[idx] : DEAD});
          end else begin
            m_wc = m_wc + 16'd1;
            if (hit && b_in[0]) mdl_mem[idx][7:0] = d_in[7:0];
            if (hit && b_in[1]) mdl_mem[idx][15:8] = d_in[15:8];
          end
        end
      end
      #1 check($sformatf("rnd%0d waitrequest", n), wreq[0], 1'b0);
    end
    @(negedge clk);
    idle(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
